// File: rtl/m3_pkg.sv
// m3_pkg: shared FSM/direction types, P_MAX constants and the clamp helper
package m3_pkg;
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_e;
  typedef enum logic {DIR_INC, DIR_DEC} dir_e;
  localparam int P_MAX_SIM = 300;
  localparam int P_MAX_SYN = 4000000;
  function automatic logic [31:0] clamp(input logic [31:0] v, input logic [31:0] lo, input logic [31:0] hi);
    return v < lo ? lo : (v > hi ? hi : v);
  endfunction
endpackage

// File: rtl/m3_period_ramp.sv
// m3_period_ramp: period register with round-divided ramp, direct load and stop/leave handling
module m3_period_ramp import m3_pkg::*; #(
  parameter int PW = 22,
  parameter int P_MAX = P_MAX_SYN,
  parameter int P_MIN = 40,
  parameter int RAMP_SH = 4,
  parameter int ROUND_DIV = 3,
  parameter int KEEP_PERIOD = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wrap,
  input  logic          inc,
  input  logic          dec,
  input  logic          load,
  input  logic [PW-1:0] load_val,
  input  logic          stop,
  input  logic          leave,
  output logic [PW-1:0] period,
  output logic [PW-1:0] period_nxt,
  output logic          at_min,
  output logic          at_max
);
  localparam int DW = $clog2(ROUND_DIV + 2);
  localparam logic [PW-1:0] PMAX = PW'(P_MAX);
  localparam logic [PW-1:0] PMIN = PW'(P_MIN);
  localparam logic [DW-1:0] RD = DW'(ROUND_DIV);
  logic [PW-1:0] period_q, period_d, dn;
  logic [PW:0] up;
  logic [DW-1:0] div_q, div_d;
  dir_e dir_q, dir_d;
  // Priority: stop, then leaving run, then load, then ramp on a wrapping step
  always_comb begin
    dn = period_q - (period_q >> RAMP_SH);
    up = {1'b0, period_q} + {1'b0, period_q >> RAMP_SH};
    period_d = period_q;
    div_d = div_q;
    dir_d = dir_q;
    if (stop || leave) begin
      period_d = (stop || KEEP_PERIOD == 0) ? PMAX : period_q;
      div_d = RD;
    end else if (load) begin
      period_d = PW'(clamp(32'(load_val), 32'(P_MIN), 32'(P_MAX)));
      div_d = RD;
    end else if (wrap) begin
      div_d = RD;
      if (inc || dec) begin
        dir_d = inc ? DIR_INC : DIR_DEC;
        if (dir_d == dir_q && div_q != '0) div_d = div_q - DW'(1);
        if (dir_d == dir_q && div_q == '0)
          period_d = inc ? (dn < PMIN ? PMIN : dn) : (up > {1'b0, PMAX} ? PMAX : up[PW-1:0]);
      end
    end
  end
  // Period, divider and last ramp direction registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      period_q <= PMAX;
      div_q <= RD;
      dir_q <= DIR_INC;
    end else begin
      period_q <= period_d;
      div_q <= div_d;
      dir_q <= dir_d;
    end
  assign period = period_q;
  assign period_nxt = period_d;
  assign at_min = period_q == PMIN;
  assign at_max = period_q == PMAX;
endmodule

// File: rtl/m3_step_seq_gen.sv
// m3_step_seq_gen: reversible commutation step sequencer with ramped step period
module m3_step_seq_gen import m3_pkg::*; #(
  parameter int PW = 22,
  parameter int P_MAX = P_MAX_SYN,
  parameter int P_MIN = 40,
  parameter int STEPS = 12,
  parameter int SW = 4,
  parameter int RAMP_SH = 4,
  parameter int ROUND_DIV = 3,
  parameter int KEEP_PERIOD = 0
) (
  input  logic          clkI,
  input  logic          nRstI,
  input  logic          enI,
  input  logic          stopI,
  input  logic          invI,
  input  logic          incI,
  input  logic          decI,
  input  logic          periodLdI,
  input  logic [PW-1:0] periodI,
  output logic [SW-1:0] stepO,
  output logic          stepPulseO,
  output logic          roundPulseO,
  output logic [PW-1:0] periodO,
  output logic          runningO,
  output logic          atMinO,
  output logic          atMaxO
);
  localparam logic [SW-1:0] LAST = SW'(STEPS - 1);
  state_e state_q, state_d;
  logic [PW-1:0] remain_q, remain_d, period_nxt;
  logic [SW-1:0] step_q, step_d;
  logic step_pulse_q, step_pulse_d, round_pulse_q, round_pulse_d, running_q;
  logic go, live, leave, bound, wrap;
  assign go = enI && !stopI;
  assign live = state_q == RUN && go;
  assign leave = state_q != IDLE && !go;
  assign bound = live && remain_q == PW'(1);
  assign wrap = bound && (invI ? step_q == '0 : step_q == LAST);
  m3_period_ramp #(
    .PW(PW), .P_MAX(P_MAX), .P_MIN(P_MIN), .RAMP_SH(RAMP_SH), .ROUND_DIV(ROUND_DIV), .KEEP_PERIOD(KEEP_PERIOD)
  ) u_ramp (
    .clk(clkI), .rst_n(nRstI), .wrap(wrap), .inc(incI), .dec(decI), .load(periodLdI), .load_val(periodI),
    .stop(stopI), .leave(leave), .period(periodO), .period_nxt(period_nxt), .at_min(atMinO), .at_max(atMaxO)
  );
  // Next state, step countdown reload and step index advance
  always_comb begin
    state_d = !go ? IDLE : (state_q == IDLE ? PRIME : RUN);
    remain_d = (!live || bound) ? period_nxt : remain_q - PW'(1);
    step_d = !live ? '0 : !bound ? step_q :
             invI ? (step_q == '0 ? LAST : step_q - SW'(1)) : (wrap ? '0 : step_q + SW'(1));
    step_pulse_d = bound;
    round_pulse_d = wrap;
  end
  // Sequencer state registers
  always_ff @(posedge clkI or negedge nRstI)
    if (!nRstI) begin
      state_q <= IDLE;
      remain_q <= PW'(P_MAX);
      step_q <= '0;
      step_pulse_q <= 1'b0;
      round_pulse_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q <= state_d;
      remain_q <= remain_d;
      step_q <= step_d;
      step_pulse_q <= step_pulse_d;
      round_pulse_q <= round_pulse_d;
      running_q <= state_d == RUN;
    end
  assign stepO = step_q;
  assign stepPulseO = step_pulse_q;
  assign roundPulseO = round_pulse_q;
  assign runningO = running_q;
endmodule

// File: tb/tb_m3_step_seq_gen.sv
// tb_m3_step_seq_gen: scoreboard bench checking step pulses, ramp, load, stop and reset
module tb_m3_step_seq_gen;
  import m3_pkg::*;
  localparam int PW = 22;
  localparam int SW = 4;
  typedef struct {logic [SW-1:0] step; logic rnd; logic [PW-1:0] per; int gap;} exp_t;
  exp_t q[$];
  exp_t e;
  logic clk = 0, nrst = 0, en = 0, stop = 0, inv = 0, inc = 0, dec = 0, ld = 0;
  logic [PW-1:0] pin = '0;
  logic [SW-1:0] step, step_k;
  logic [PW-1:0] per, per_k;
  logic sp, rp, run, amin, amax, sp_k, rp_k, run_k, amin_k, amax_k;
  logic run_prev = 0;
  int checks = 0, errors = 0, cyc = 0, last = 0, s = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  m3_step_seq_gen #(.P_MAX(P_MAX_SIM)) dut (
    .clkI(clk), .nRstI(nrst), .enI(en), .stopI(stop), .invI(inv), .incI(inc), .decI(dec),
    .periodLdI(ld), .periodI(pin), .stepO(step), .stepPulseO(sp), .roundPulseO(rp),
    .periodO(per), .runningO(run), .atMinO(amin), .atMaxO(amax));

  m3_step_seq_gen #(.P_MAX(P_MAX_SIM), .KEEP_PERIOD(1)) dut_k (
    .clkI(clk), .nRstI(nrst), .enI(en), .stopI(stop), .invI(inv), .incI(inc), .decI(dec),
    .periodLdI(ld), .periodI(pin), .stepO(step_k), .stepPulseO(sp_k), .roundPulseO(rp_k),
    .periodO(per_k), .runningO(run_k), .atMinO(amin_k), .atMaxO(amax_k));

  // Scoreboard consumer: every step pulse must match the oldest expectation
  always @(negedge clk) begin
    if (run && !run_prev) last = cyc;
    run_prev = run;
    if (rp && !sp) begin
      checks++; errors++;
      $display("FAIL round_without_step step=%0d", step);
    end
    if (sp) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse step=%0d round=%0b", step, rp);
      end else begin
        e = q.pop_front();
        checks++;
        if (step !== e.step) begin errors++; $display("FAIL sb_step got=%0d want=%0d", step, e.step); end
        checks++;
        if (rp !== e.rnd) begin errors++; $display("FAIL sb_round got=%0b want=%0b step=%0d", rp, e.rnd, step); end
        checks++;
        if (per !== e.per) begin errors++; $display("FAIL sb_period got=%0d want=%0d step=%0d", per, e.per, step); end
        checks++;
        if (cyc - last != e.gap) begin errors++; $display("FAIL sb_gap got=%0d want=%0d step=%0d", cyc - last, e.gap, step); end
      end
      last = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push(input logic i, input int p, input int g);
    int n;
    n = i ? (s == 0 ? 11 : s - 1) : (s == 11 ? 0 : s + 1);
    q.push_back('{step: SW'(n), rnd: (i ? s == 0 : s == 11), per: PW'(p), gap: g});
    s = n;
  endtask

  task automatic push_round(input int g0, input int p, input int pw);
    for (int i = 0; i < 12; i++) push(1'b0, i == 11 ? pw : p, i == 0 ? g0 : p);
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && q.size() != 0; i++) tick(1);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d want=0", q.size());
      q.delete();
    end
  endtask

  task automatic load(input int v);
    pin = PW'(v);
    ld = 1;
    tick(1);
    ld = 0;
  endtask

  task automatic test_reset;
    nrst = 0;
    tick(3);
    nrst = 1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      checks++;
      if (step !== 0 || sp !== 0 || rp !== 0 || run !== 0)
        begin errors++; $display("FAIL reset_idle step=%0d sp=%0b rp=%0b run=%0b want 0", step, sp, rp, run); end
    end
    checks++;
    if (per !== 300 || amax !== 1 || amin !== 0)
      begin errors++; $display("FAIL reset_period per=%0d max=%0b min=%0b want 300/1/0", per, amax, amin); end
  endtask

  task automatic test_run;
    s = 0;
    push_round(300, 300, 300);
    en = 1;
    @(posedge clk); #1;
    checks++;
    if (run !== 0) begin errors++; $display("FAIL run_prime running=%0b want=0", run); end
    @(posedge clk); #1;
    checks++;
    if (run !== 1) begin errors++; $display("FAIL run_enter running=%0b want=1", run); end
    drain(3700);
  endtask

  task automatic test_ramp_inc;
    int p;
    inc = 1;
    for (int r = 1; r <= 8; r++) begin
      p = r <= 4 ? 300 : 282;
      push_round(p, p, r == 4 ? 282 : (r == 8 ? 265 : p));
      drain(12 * p + 20);
    end
    push_round(265, 44, 44);
    load(44);
    drain(265 + 11 * 44 + 20);
    for (int w = 2; w <= 12; w++) begin
      p = w <= 4 ? 44 : (w <= 8 ? 42 : 40);
      push_round(p, p, w == 4 ? 42 : (w == 8 ? 40 : p));
      drain(12 * p + 20);
      if (w == 8) begin
        checks++;
        if (per !== 40 || amin !== 1) begin errors++; $display("FAIL ramp_min per=%0d min=%0b want 40/1", per, amin); end
      end
    end
    checks++;
    if (per !== 40 || amin !== 1) begin errors++; $display("FAIL ramp_min_hold per=%0d min=%0b want 40/1", per, amin); end
  endtask

  task automatic test_ramp_dec;
    inc = 0;
    dec = 1;
    for (int r = 1; r <= 5; r++) begin
      push_round(40, 40, r == 5 ? 42 : 40);
      drain(12 * 40 + 20);
    end
    checks++;
    if (per !== 42 || amin !== 0) begin errors++; $display("FAIL dec_step per=%0d min=%0b want 42/0", per, amin); end
  endtask

  task automatic test_toggle;
    for (int r = 1; r <= 4; r++) begin
      inc = r[0];
      dec = !r[0];
      push_round(42, 42, 42);
      drain(12 * 42 + 20);
    end
    checks++;
    if (per !== 42) begin errors++; $display("FAIL toggle_hold per=%0d want=42", per); end
  endtask

  task automatic test_clamp_max;
    inc = 0;
    dec = 1;
    push_round(42, 290, 290);
    load(290);
    drain(42 + 11 * 290 + 20);
    for (int w = 2; w <= 4; w++) begin
      push_round(290, 290, w == 4 ? 300 : 290);
      drain(12 * 290 + 20);
    end
    checks++;
    if (per !== 300 || amax !== 1) begin errors++; $display("FAIL dec_clamp per=%0d max=%0b want 300/1", per, amax); end
    dec = 0;
  endtask

  task automatic test_reverse;
    push(1'b0, 40, 300);
    load(40);
    push(1'b0, 40, 40);
    push(1'b0, 40, 40);
    drain(400);
    inv = 1;
    for (int i = 0; i < 5; i++) push(1'b1, 40, 40);
    drain(5 * 40 + 20);
    inv = 0;
    push(1'b0, 40, 40);
    push(1'b0, 40, 40);
    drain(2 * 40 + 20);
    checks++;
    if (step !== 0) begin errors++; $display("FAIL reverse_end step=%0d want=0", step); end
  endtask

  task automatic test_stop;
    push(1'b0, 40, 40);
    drain(60);
    load(100);
    checks++;
    if (per !== 100 || run !== 1 || step !== 1)
      begin errors++; $display("FAIL load_run per=%0d run=%0b step=%0d want 100/1/1", per, run, step); end
    stop = 1;
    tick(1);
    checks++;
    if (run !== 0 || step !== 0 || per !== 300 || amax !== 1 || per_k !== 300)
      begin errors++; $display("FAIL stop run=%0b step=%0d per=%0d max=%0b per_k=%0d want 0/0/300/1/300", run, step, per, amax, per_k); end
    stop = 0;
    en = 0;
    s = 0;
    tick(3);
  endtask

  task automatic test_load_clamp;
    load(10);
    checks++;
    if (per !== 40 || amin !== 1) begin errors++; $display("FAIL load_low per=%0d min=%0b want 40/1", per, amin); end
    load(5000);
    checks++;
    if (per !== 300 || amax !== 1) begin errors++; $display("FAIL load_high per=%0d max=%0b want 300/1", per, amax); end
    load(120);
    checks++;
    if (per !== 120 || per_k !== 120) begin errors++; $display("FAIL load_mid per=%0d per_k=%0d want 120", per, per_k); end
  endtask

  task automatic test_keep;
    en = 1;
    tick(3);
    checks++;
    if (run !== 1 || run_k !== 1) begin errors++; $display("FAIL keep_run run=%0b run_k=%0b want 1", run, run_k); end
    en = 0;
    tick(1);
    checks++;
    if (run !== 0 || run_k !== 0 || per !== 300 || per_k !== 120)
      begin errors++; $display("FAIL keep_drop run=%0b run_k=%0b per=%0d per_k=%0d want 0/0/300/120", run, run_k, per, per_k); end
  endtask

  task automatic test_reset_mid;
    load(40);
    s = 0;
    push(1'b0, 40, 40);
    en = 1;
    drain(60);
    tick(5);
    #2;
    nrst = 0;
    #1;
    checks++;
    if (run !== 0 || step !== 0 || sp !== 0 || rp !== 0 || per !== 300 || amax !== 1 || per_k !== 300)
      begin errors++; $display("FAIL reset_mid run=%0b step=%0d sp=%0b per=%0d per_k=%0d want 0/0/0/300/300", run, step, sp, per, per_k); end
    tick(50);
    en = 0;
    nrst = 1;
    tick(2);
    checks++;
    if (run !== 0 || step !== 0) begin errors++; $display("FAIL reset_release run=%0b step=%0d want 0/0", run, step); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_ramp_inc();
    test_ramp_dec();
    test_toggle();
    test_clamp_max();
    test_reverse();
    test_stop();
    test_load_clamp();
    test_keep();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
